// File: rtl/dtc_seq_walker_pkg.sv
// dtc_pkg: node word geometry helpers, default node struct and walker FSM states.
package dtc_pkg;

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    function automatic int fi_w(input int num_feat);
        return num_feat > 1 ? $clog2(num_feat) : 1;
    endfunction

    function automatic int node_aw(input int num_nodes);
        return num_nodes > 1 ? $clog2(num_nodes) : 1;
    endfunction

    function automatic int node_w(input int num_feat, input int num_nodes, input int cls_w);
        return 1 + fi_w(num_feat) + 2 * node_aw(num_nodes) + cls_w;
    endfunction

    function automatic int c1_lo(input int cls_w);
        return cls_w;
    endfunction

    function automatic int c0_lo(input int num_nodes, input int cls_w);
        return cls_w + node_aw(num_nodes);
    endfunction

    function automatic int fi_lo(input int num_nodes, input int cls_w);
        return cls_w + 2 * node_aw(num_nodes);
    endfunction

    localparam int DEF_FI_W  = fi_w(11);
    localparam int DEF_AW    = node_aw(16);
    localparam int DEF_CLS_W = 3;

    typedef struct packed {
        logic                 leaf;
        logic [DEF_FI_W-1:0]  feat_idx;
        logic [DEF_AW-1:0]    child0;
        logic [DEF_AW-1:0]    child1;
        logic [DEF_CLS_W-1:0] cls;
    } node_t;

endpackage

// File: rtl/dtc_seq_walker_if.sv
// dtc_seq_walker_if: request, result and node-table config bundle; DTC_PATH_TRACE_EN adds the path trace.
interface dtc_seq_walker_if #(
    parameter int NUM_FEAT  = 11,
    parameter int CLS_W     = 3,
    parameter int NUM_NODES = 16,
    parameter int MAX_DEPTH = 15
);
    import dtc_pkg::*;

    localparam int AW     = node_aw(NUM_NODES);
    localparam int NODE_W = node_w(NUM_FEAT, NUM_NODES, CLS_W);
    localparam int LW     = $clog2(MAX_DEPTH + 1);

    logic                in_valid;
    logic                in_ready;
    logic [NUM_FEAT-1:0] inp;
    logic                out_valid;
    logic                out_ready;
    logic [CLS_W-1:0]    outp;
    logic                out_err;
    logic                cfg_we;
    logic                cfg_ready;
    logic [AW-1:0]       cfg_addr;
    logic [NODE_W-1:0]   cfg_data;
`ifdef DTC_PATH_TRACE_EN
    logic [MAX_DEPTH-1:0] out_path;
    logic [LW-1:0]        out_len;

    modport master (
        output in_valid, inp, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, outp, out_err, cfg_ready, out_path, out_len
    );
    modport slave (
        input  in_valid, inp, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, outp, out_err, cfg_ready, out_path, out_len
    );
`else
    modport master (
        output in_valid, inp, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, outp, out_err, cfg_ready
    );
    modport slave (
        input  in_valid, inp, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, outp, out_err, cfg_ready
    );
`endif

endinterface

// File: rtl/dtc_seq_walker_node_ram.sv
// dtc_node_ram: node table register file, resets to leaf/class 0, sync write, combinational read.
module dtc_node_ram #(
    parameter int NUM_NODES = 16,
    parameter int NODE_W    = 16,
    parameter int AW        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [NODE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [NODE_W-1:0] rdata
);
    localparam logic [NODE_W-1:0] RST_WORD = {1'b1, {(NODE_W-1){1'b0}}};

    logic [NODE_W-1:0] mem [NUM_NODES];

    // every entry clears to a class-0 leaf; writes land on the clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NODES; i++) mem[i] <= RST_WORD;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dtc_seq_walker.sv
// dtc_seq_walker: walks a loadable decision tree one node per clock; DTC_PATH_TRACE_EN adds out_path/out_len.
module dtc_seq_walker
    import dtc_pkg::*;
#(
    parameter int              NUM_FEAT  = 11,
    parameter int              CLS_W     = 3,
    parameter int              NUM_NODES = 16,
    parameter int              MAX_DEPTH = 15,
    parameter logic [CLS_W-1:0] ERR_CLASS = '1
) (
    input logic             clk,
    input logic             rst_n,
    dtc_seq_walker_if.slave bus
);
    localparam int FI_W   = fi_w(NUM_FEAT);
    localparam int AW     = node_aw(NUM_NODES);
    localparam int NODE_W = node_w(NUM_FEAT, NUM_NODES, CLS_W);
    localparam int SW     = $clog2(MAX_DEPTH + 1);
    localparam int PW     = 2 ** FI_W;
    localparam int C1_LO  = c1_lo(CLS_W);
    localparam int C0_LO  = c0_lo(NUM_NODES, CLS_W);
    localparam int FI_LO  = fi_lo(NUM_NODES, CLS_W);

    state_t              st;
    logic [AW-1:0]       cur;
    logic [SW-1:0]       step;
    logic [NUM_FEAT-1:0] inp_q;
    logic [NODE_W-1:0]   node;
    logic [PW-1:0]       inp_pad;
    logic                n_leaf;
    logic                dir;
    logic                last;
    logic [AW-1:0]       n_next;

    dtc_node_ram #(.NUM_NODES(NUM_NODES), .NODE_W(NODE_W), .AW(AW)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bus.cfg_we && bus.cfg_ready),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .raddr (cur),
        .rdata (node)
    );

    // zero padding makes any feat_idx >= NUM_FEAT test a 0 bit
    assign inp_pad = PW'(inp_q);
    assign n_leaf  = node[NODE_W-1];
    assign dir     = inp_pad[node[FI_LO +: FI_W]];
    assign n_next  = dir ? node[C1_LO +: AW] : node[C0_LO +: AW];
    assign last    = (step + 1'b1) == SW'(MAX_DEPTH);

    // walker FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            cur           <= '0;
            step          <= '0;
            inp_q         <= '0;
            bus.in_ready  <= 1'b1;
            bus.cfg_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.outp      <= '0;
            bus.out_err   <= 1'b0;
`ifdef DTC_PATH_TRACE_EN
            bus.out_path  <= '0;
            bus.out_len   <= '0;
`endif
        end else begin
            case (st)
                IDLE: if (bus.in_valid && bus.in_ready) begin
                    inp_q         <= bus.inp;
                    cur           <= '0;
                    step          <= '0;
                    bus.in_ready  <= 1'b0;
                    bus.cfg_ready <= 1'b0;
                    st            <= WALK;
`ifdef DTC_PATH_TRACE_EN
                    bus.out_path  <= '0;
                    bus.out_len   <= '0;
`endif
                end
                WALK: begin
                    step <= step + 1'b1;
                    if (n_leaf || last) begin
                        bus.outp      <= n_leaf ? node[CLS_W-1:0] : ERR_CLASS;
                        bus.out_err   <= !n_leaf;
                        bus.out_valid <= 1'b1;
                        st            <= DONE;
`ifdef DTC_PATH_TRACE_EN
                        bus.out_len   <= step + 1'b1;
`endif
                    end else begin
                        cur <= n_next;
`ifdef DTC_PATH_TRACE_EN
                        bus.out_path[step] <= dir;
`endif
                    end
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    bus.cfg_ready <= 1'b1;
                    st            <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dtc_seq_walker.sv
// tb_dtc_seq_walker: directed checks of the tree walker (tree walk, depth guard, back-pressure, cfg lockout, reset).
module tb_dtc_seq_walker;
    import dtc_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [2:0] c;
    logic       e;
    int         lat;
`ifdef DTC_PATH_TRACE_EN
    logic [14:0] got_path;
    logic [3:0]  got_len;
`endif

    dtc_seq_walker_if #(.NUM_FEAT(11), .CLS_W(3), .NUM_NODES(16), .MAX_DEPTH(15)) bus ();

    dtc_seq_walker #(.NUM_FEAT(11), .CLS_W(3), .NUM_NODES(16), .MAX_DEPTH(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic leaf, input logic [3:0] f,
                                       input logic [3:0] c0, input logic [3:0] c1,
                                       input logic [2:0] cls);
        node_t n;
        n.leaf     = leaf;
        n.feat_idx = f;
        n.child0   = c0;
        n.child1   = c1;
        n.cls      = cls;
        return n;
    endfunction

    task automatic write_node(input logic [3:0] a, input logic [15:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        @(posedge clk); #1;
        bus.cfg_we   = 1'b0;
    endtask

    task automatic run(input logic [10:0] v, output logic [2:0] rc, output logic re, output int rl);
        bus.inp      = v;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rl = 0;
        while (!bus.out_valid && rl < 40) begin
            @(posedge clk); #1;
            rl++;
        end
        rc = bus.outp;
        re = bus.out_err;
`ifdef DTC_PATH_TRACE_EN
        got_path = bus.out_path;
        got_len  = bus.out_len;
`endif
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cfg_ready got %b want 1", bus.cfg_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.outp !== 3'b000) begin n_bad++; $display("FAIL reset_outp got %b want 000", bus.outp); end
        n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got %b want 0", bus.out_err); end
`ifdef DTC_PATH_TRACE_EN
        n_cmp++; if (bus.out_path !== 15'd0) begin n_bad++; $display("FAIL reset_out_path got %h want 0", bus.out_path); end
        n_cmp++; if (bus.out_len !== 4'd0) begin n_bad++; $display("FAIL reset_out_len got %0d want 0", bus.out_len); end
`endif
    endtask

    task automatic test_tree;
        logic [10:0] vin  [4] = '{11'h000, 11'h001, 11'h011, 11'h008};
        logic [2:0]  vcls [4] = '{3'b101, 3'b111, 3'b001, 3'b000};
        int          vlat [4] = '{4, 4, 4, 2};
        write_node(4'd0, mk(1'b0, 4'd3, 4'd1, 4'd2, 3'd0));
        write_node(4'd1, mk(1'b0, 4'd4, 4'd3, 4'd4, 3'd0));
        write_node(4'd2, mk(1'b1, 4'd0, 4'd0, 4'd0, 3'b000));
        write_node(4'd3, mk(1'b0, 4'd0, 4'd5, 4'd6, 3'd0));
        write_node(4'd4, mk(1'b0, 4'd0, 4'd5, 4'd7, 3'd0));
        write_node(4'd5, mk(1'b1, 4'd0, 4'd0, 4'd0, 3'b101));
        write_node(4'd6, mk(1'b1, 4'd0, 4'd0, 4'd0, 3'b111));
        write_node(4'd7, mk(1'b1, 4'd0, 4'd0, 4'd0, 3'b001));
        for (int i = 0; i < 4; i++) begin
            run(vin[i], c, e, lat);
            n_cmp++; if (c !== vcls[i]) begin n_bad++; $display("FAIL tree_cls inp=%h got %b want %b", vin[i], c, vcls[i]); end
            n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL tree_err inp=%h got %b want 0", vin[i], e); end
            n_cmp++; if (lat != vlat[i]) begin n_bad++; $display("FAIL tree_lat inp=%h got %0d want %0d", vin[i], lat, vlat[i]); end
        end
    endtask

`ifdef DTC_PATH_TRACE_EN
    task automatic test_path;
        run(11'h011, c, e, lat);
        n_cmp++; if (got_path !== 15'b000000000000110) begin n_bad++; $display("FAIL path_bits got %b want 110", got_path); end
        n_cmp++; if (got_len !== 4'd4) begin n_bad++; $display("FAIL path_len got %0d want 4", got_len); end
    endtask
`endif

    task automatic test_cfg_during_walk;
        bus.inp      = 11'h000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL walk_cfg_ready got %b want 0", bus.cfg_ready); end
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 4'd5;
        bus.cfg_data = mk(1'b1, 4'd0, 4'd0, 4'd0, 3'b010);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        lat = 2;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (bus.outp !== 3'b101) begin n_bad++; $display("FAIL walk_cfg_cls got %b want 101", bus.outp); end
        n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL walk_cfg_lat got %0d want 4", lat); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        run(11'h000, c, e, lat);
        n_cmp++; if (c !== 3'b101) begin n_bad++; $display("FAIL walk_cfg_after got %b want 101", c); end
    endtask

    task automatic test_back_pressure;
        bus.inp      = 11'h008;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid got %b want 1", bus.out_valid); end
        bus.inp      = 11'h000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.outp !== 3'b000 || bus.in_ready !== 1'b0)
                begin n_bad++; $display("FAIL bp_hold cyc=%0d got v=%b o=%b r=%b want v=1 o=000 r=0", i, bus.out_valid, bus.outp, bus.in_ready); end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin n_bad++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_second_accept got %b want 0", bus.in_ready); end
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (bus.outp !== 3'b101) begin n_bad++; $display("FAIL bp_second_cls got %b want 101", bus.outp); end
        n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL bp_second_lat got %0d want 4", lat); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_depth_guard;
        write_node(4'd0, mk(1'b0, 4'd0, 4'd0, 4'd0, 3'd0));
        run(11'h000, c, e, lat);
        n_cmp++; if (c !== 3'b111) begin n_bad++; $display("FAIL depth_cls got %b want 111", c); end
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL depth_err got %b want 1", e); end
        n_cmp++; if (lat != 15) begin n_bad++; $display("FAIL depth_lat got %0d want 15", lat); end
`ifdef DTC_PATH_TRACE_EN
        n_cmp++; if (got_len !== 4'd15) begin n_bad++; $display("FAIL depth_len got %0d want 15", got_len); end
`endif
    endtask

    task automatic test_reset_mid_walk;
        bus.inp      = 11'h000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.cfg_ready !== 1'b1)
            begin n_bad++; $display("FAIL rst_async got v=%b r=%b cr=%b want 0 1 1", bus.out_valid, bus.in_ready, bus.cfg_ready); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_spurious cyc=%0d got %b want 0", i, bus.out_valid); end
        end
        run(11'h000, c, e, lat);
        n_cmp++; if (c !== 3'b000) begin n_bad++; $display("FAIL rst_walk_cls got %b want 000", c); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL rst_walk_err got %b want 0", e); end
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL rst_walk_lat got %0d want 1", lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.inp       = '0;
        bus.out_ready = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset;
        test_tree;
`ifdef DTC_PATH_TRACE_EN
        test_path;
`endif
        test_cfg_during_walk;
        test_back_pressure;
        test_depth_guard;
        test_reset_mid_walk;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
